// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, req/ack imem port, registered IR and fields
// Optional macro FETCH_PREFETCH_EN adds a one-entry prefetch buffer behind the IR.
module fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [7:0]        imm,
  output logic [ADDR_W-1:0] inst_pc
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_pend_pc, w_pend_nxt;
  logic [ADDR_W-1:0] r_inst_pc, w_inst_pc_nxt;
  logic [15:0]       r_ir, w_ir_nxt;
  logic              r_inst_valid, w_valid_nxt;
  logic              w_req, w_ack, w_take;
`ifdef FETCH_PREFETCH_EN
  logic [15:0]       r_buf, w_buf_nxt;
  logic [ADDR_W-1:0] r_buf_pc, w_buf_pc_nxt;
  logic              r_buf_valid, w_buf_valid_nxt;

  assign w_req = (r_state == FETCH) || (r_state == DRAIN) || ((r_state == HOLD) && !r_buf_valid);
`else
  assign w_req = (r_state == FETCH) || (r_state == DRAIN);
`endif

  // r_pc stays on the outstanding address while draining; the redirect target waits in r_pend_pc
  assign w_ack      = imem_ack && w_req;
  assign w_take     = r_inst_valid && inst_ready;
  assign imem_req   = w_req;
  assign imem_addr  = r_pc;
  assign inst_valid = r_inst_valid;
  assign opcode     = r_ir[15:12];
  assign rd         = r_ir[11:8];
  assign rs         = r_ir[7:4];
  assign rt         = r_ir[3:0];
  assign imm        = r_ir[7:0];
  assign inst_pc    = r_inst_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= BOOT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_nxt    = r_pend_pc;
    w_ir_nxt      = r_ir;
    w_inst_pc_nxt = r_inst_pc;
    w_valid_nxt   = r_inst_valid;
`ifdef FETCH_PREFETCH_EN
    w_buf_nxt       = r_buf;
    w_buf_pc_nxt    = r_buf_pc;
    w_buf_valid_nxt = r_buf_valid;
`endif
    case (r_state)
      BOOT: begin
        if (redirect_valid) w_pc_nxt = redirect_pc;
        w_state_nxt = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          if (w_ack) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_pend_nxt  = redirect_pc;
            w_state_nxt = DRAIN;
          end
        end else if (w_ack) begin
          w_ir_nxt      = imem_rdata;
          w_inst_pc_nxt = r_pc;
          w_pc_nxt      = r_pc + 1'b1;
          w_valid_nxt   = 1'b1;
          w_state_nxt   = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          w_valid_nxt = 1'b0;
`ifdef FETCH_PREFETCH_EN
          w_buf_valid_nxt = 1'b0;
`endif
          if (w_req && !w_ack) begin
            w_pend_nxt  = redirect_pc;
            w_state_nxt = DRAIN;
          end else begin
            w_pc_nxt    = redirect_pc;
            w_state_nxt = FETCH;
          end
        end else if (w_take) begin
`ifdef FETCH_PREFETCH_EN
          if (r_buf_valid) begin
            w_ir_nxt        = r_buf;
            w_inst_pc_nxt   = r_buf_pc;
            w_buf_valid_nxt = 1'b0;
          end else if (w_ack) begin
            w_ir_nxt      = imem_rdata;
            w_inst_pc_nxt = r_pc;
            w_pc_nxt      = r_pc + 1'b1;
          end else begin
            w_valid_nxt = 1'b0;
            w_state_nxt = FETCH;
          end
`else
          w_valid_nxt = 1'b0;
          w_state_nxt = FETCH;
`endif
        end
`ifdef FETCH_PREFETCH_EN
        else if (w_ack) begin
          w_buf_nxt       = imem_rdata;
          w_buf_pc_nxt    = r_pc;
          w_buf_valid_nxt = 1'b1;
          w_pc_nxt        = r_pc + 1'b1;
        end
`endif
      end
      DRAIN: begin
        if (redirect_valid) w_pend_nxt = redirect_pc;
        if (w_ack) begin
          w_pc_nxt    = redirect_valid ? redirect_pc : r_pend_pc;
          w_state_nxt = FETCH;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc         <= RESET_PC;
      r_pend_pc    <= RESET_PC;
      r_ir         <= '0;
      r_inst_pc    <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_pend_pc    <= w_pend_nxt;
      r_ir         <= w_ir_nxt;
      r_inst_pc    <= w_inst_pc_nxt;
      r_inst_valid <= w_valid_nxt;
    end
  end

`ifdef FETCH_PREFETCH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf       <= '0;
      r_buf_pc    <= '0;
      r_buf_valid <= 1'b0;
    end else begin
      r_buf       <= w_buf_nxt;
      r_buf_pc    <= w_buf_pc_nxt;
      r_buf_valid <= w_buf_valid_nxt;
    end
  end
`endif

endmodule
